if_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and drives its pc_id / instr_payload / instr_value inputs.
- Issues word fetches on a req/gnt/rvalid instruction bus and buffers returned words in a small prefetch FIFO.
- Handles PC redirects from EX (branch/jump resolution) and from the controller (exception, interrupt, mret), discarding in-flight responses.
- 32-bit aligned fetch only: RVC is not supported and compress_instr_id is tied 0.

---
 rtl/if_stage.sv | 145 ++++++++++++++
 tb/tb_if_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch into a FIFO_DEPTH-entry prefetch buffer: head entry is presented combinationally, decode backpressures via ready_id, requests are capped by FIFO_DEPTH.
// Redirects flush the buffer and discard in-flight responses; macro IF_STATIC_BP_EN adds backward-taken static branch prediction.
module if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_rdata,
    input  logic        instr_err,
    input  logic        pc_set,
    input  logic [31:0] pc_set_addr,
    input  logic        branch_redirect_ex,
    input  logic [31:0] branch_target_ex,
    input  logic        ready_id,
    output logic [31:0] pc_id,
    output logic [31:0] instr_payload,
    output logic        instr_value,
    output logic        branch_prediction_id,
    output logic        compress_instr_id,
    output logic        instr_fetch_error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = '0;
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic             started_q;
    logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d, discard_q, discard_d, count_q, count_d, occupancy;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic             err_mem_q   [FIFO_DEPTH];
    logic             ext_redirect, pred_redirect, redirect, grant, drop, push, pop;
    logic [31:0]      redirect_target, pred_target;

    assign pc_id             = pc_mem_q[rd_ptr_q];
    assign instr_payload     = instr_mem_q[rd_ptr_q];
    assign instr_fetch_error = err_mem_q[rd_ptr_q];
    assign compress_instr_id = 1'b0;

    assign ext_redirect = pc_set | branch_redirect_ex;
    assign instr_value  = (count_q != ZERO_C) & ~ext_redirect;
    assign pop          = instr_value & ready_id;

`ifdef IF_STATIC_BP_EN
    logic        head_pred;
    logic [31:0] imm_b;
    assign head_pred = (instr_payload[6:0] == 7'b1100011) & instr_payload[31];
    assign imm_b     = {{20{instr_payload[31]}}, instr_payload[7], instr_payload[30:25],
                        instr_payload[11:8], 1'b0};
    assign branch_prediction_id = instr_value & head_pred;
    assign pred_redirect        = pop & head_pred;
    assign pred_target          = pc_id + imm_b;
`else
    assign branch_prediction_id = 1'b0;
    assign pred_redirect        = 1'b0;
    assign pred_target          = 32'h0;
`endif

    assign redirect        = ext_redirect | pred_redirect;
    assign redirect_target = (pc_set             ? pc_set_addr :
                              branch_redirect_ex ? branch_target_ex : pred_target) & ~32'h3;

    // A pop this cycle frees a slot, so a full buffer can still issue a request.
    assign occupancy  = outst_q + count_q - (pop ? ONE_C : ZERO_C);
    assign instr_req  = started_q & ~redirect & (occupancy < DEPTH_C);
    assign instr_addr = fetch_pc_q;
    assign grant      = instr_req & instr_gnt;
    assign drop       = instr_rvalid & (discard_q != ZERO_C);
    assign push       = instr_rvalid & ~drop & ~redirect;

    assign outst_d = outst_q + (grant ? ONE_C : ZERO_C) - (instr_rvalid ? ONE_C : ZERO_C);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            discard_d  = outst_q - (instr_rvalid ? ONE_C : ZERO_C);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (drop)  discard_d  = discard_q - ONE_C;
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (push ? ONE_C : ZERO_C) - (pop ? ONE_C : ZERO_C);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q  <= 1'b0;
            fetch_pc_q <= BOOT_ADDR;
            resp_pc_q  <= BOOT_ADDR;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                err_mem_q[i]   <= 1'b0;
            end
        end else begin
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= resp_pc_q;
                instr_mem_q[wr_ptr_q] <= instr_err ? NOP : instr_rdata;
                err_mem_q[wr_ptr_q]   <= instr_err;
            end
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!reset_n) push |-> ((count_q < DEPTH_C) || pop));
`endif

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;
    localparam logic [31:0] BOOT = 32'h0000_0080;
    localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef IF_STATIC_BP_EN
    localparam logic [31:0] AFTER_90 = 32'h0000_008C;
    localparam logic [31:0] PRED_90  = 32'h1;
`else
    localparam logic [31:0] AFTER_90 = 32'h0000_0094;
    localparam logic [31:0] PRED_90  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt = 1'b0;
    logic        instr_rvalid = 1'b0;
    logic [31:0] instr_rdata = '0;
    logic        instr_err = 1'b0;
    logic        pc_set = 1'b0;
    logic [31:0] pc_set_addr = '0;
    logic        branch_redirect_ex = 1'b0;
    logic [31:0] branch_target_ex = '0;
    logic        ready_id = 1'b0;
    logic [31:0] pc_id, instr_payload;
    logic        instr_value, branch_prediction_id, compress_instr_id, instr_fetch_error;

    typedef struct { logic [31:0] pc; logic [31:0] payload; logic err; logic pred; } exp_t;
    typedef struct { logic [31:0] addr; int cyc; int lat; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc = BOOT;
    int checks = 0, errors = 0, cyc = 0, pops = 0, phase = 0;
    int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, bp_armed = 1'b0, bp_done = 1'b0;
    logic [31:0] prev_addr = '0;

    if_stage dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
        .pc_set(pc_set), .pc_set_addr(pc_set_addr),
        .branch_redirect_ex(branch_redirect_ex), .branch_target_ex(branch_target_ex),
        .ready_id(ready_id), .pc_id(pc_id), .instr_payload(instr_payload),
        .instr_value(instr_value), .branch_prediction_id(branch_prediction_id),
        .compress_instr_id(compress_instr_id), .instr_fetch_error(instr_fetch_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Program image: low memory is straight-line code except a backward beq at 0x90.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h5BD1_E995;
        if (a == 32'h90) return 32'hFE00_0EE3;
        if (a < 32'h1000) return {h[31:7], 7'b0010011};
        if (h[2:0] == 3'd0) return {h[31:25], 10'd0, 3'b000, h[11:7], 7'b1100011};
        return h;
    endfunction

    function automatic logic err_at(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h85EB_CA6B) ^ (a >> 3);
        return (a == 32'h84) || (a >= 32'h1000 && h[3:0] == 4'd5);
    endfunction

    function automatic logic [31:0] bimm(input logic [31:0] w);
        int v;
        v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return 32'(v);
    endfunction

    function automatic exp_t entry_at(input logic [31:0] p);
        exp_t e;
        e.pc      = p;
        e.err     = err_at(p);
        e.payload = e.err ? NOP : mem_word(p);
`ifdef IF_STATIC_BP_EN
        e.pred    = (e.payload[6:0] == 7'b1100011) && e.payload[31];
`else
        e.pred    = 1'b0;
`endif
        return e;
    endfunction

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e = entry_at(model_pc);
            exp_q.push_back(e);
            model_pc = e.pred ? e.pc + bimm(e.payload) : e.pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is at posedge+2; redirect is held for exactly one cycle.
    task automatic do_redirect(input logic ps, input logic br, input logic [31:0] ps_t, input logic [31:0] br_t);
        pc_set = ps; branch_redirect_ex = br; pc_set_addr = ps_t; branch_target_ex = br_t;
        exp_q.delete();
        model_pc = (ps ? ps_t : br_t) & ~32'h3;
        refill();
        @(posedge clk); #2;
        pc_set = 1'b0; branch_redirect_ex = 1'b0;
        pc_set_addr = $urandom; branch_target_ex = $urandom;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        int n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (instr_value && ready_id) begin
                seen = 1'b1;
                chk(name, pc_id, exp_pc);
            end
        end
        chk({name, "_seen"}, {31'b0, seen}, 32'h1);
    endtask

    // In-order bus responder.
    always @(posedge clk) begin
        #1;
        instr_gnt    = ($urandom_range(99) < gnt_pct);
        instr_rvalid = 1'b0;
        instr_err    = 1'b0;
        instr_rdata  = $urandom;
        if (reset_n && pend_q.size() > 0 && (cyc - pend_q[0].cyc) >= pend_q[0].lat
            && $urandom_range(99) < rv_pct) begin
            instr_rvalid = 1'b1;
            instr_rdata  = mem_word(pend_q[0].addr);
            instr_err    = err_at(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
    end

    // Monitor: protocol checks, scoreboard comparison and grant recording.
    always @(negedge clk) begin
        exp_t  e;
        pend_t p;
        if (reset_n) begin
            if (instr_req) chk("addr_align", {30'b0, instr_addr[1:0]}, 32'h0);
            if (pc_set || branch_redirect_ex) begin
                chk("value_in_redirect", {31'b0, instr_value}, 32'h0);
                chk("req_in_redirect", {31'b0, instr_req}, 32'h0);
            end
            if (prev_req && !prev_gnt) begin
                chk("addr_held", instr_addr, prev_addr);
                if (!(pc_set || branch_redirect_ex || (branch_prediction_id && ready_id)))
                    chk("req_held", {31'b0, instr_req}, 32'h1);
            end
            chk("compress", {31'b0, compress_instr_id}, 32'h0);
            if (instr_value && ready_id) begin
                refill();
                e = exp_q.pop_front();
                refill();
                chk("pop_pc", pc_id, e.pc);
                chk("pop_payload", instr_payload, e.payload);
                chk("pop_err", {31'b0, instr_fetch_error}, {31'b0, e.err});
                chk("pop_pred", {31'b0, branch_prediction_id}, {31'b0, e.pred});
                pops++;
                if (phase == 1) begin
                    if (bp_armed && !bp_done) begin
                        chk("after_bp", pc_id, AFTER_90);
                        bp_done = 1'b1;
                    end
                    if (pc_id == 32'h90 && !bp_armed) begin
                        chk("bp_flag_90", {31'b0, branch_prediction_id}, PRED_90);
                        bp_armed = 1'b1;
                    end
                    if (pc_id == 32'h84) begin
                        chk("err84_flag", {31'b0, instr_fetch_error}, 32'h1);
                        chk("err84_nop", instr_payload, NOP);
                    end
                    if (pc_id == 32'h80 || pc_id == 32'h88)
                        chk("err_neighbour", {31'b0, instr_fetch_error}, 32'h0);
                end
            end
            if (instr_req && instr_gnt) begin
                p.addr = instr_addr;
                p.cyc  = cyc;
                p.lat  = $urandom_range(lat_max, lat_min);
                pend_q.push_back(p);
            end
            prev_req  = instr_req;
            prev_gnt  = instr_gnt;
            prev_addr = instr_addr;
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cyc, val_cyc, n, p0, r;
        logic [31:0] t1, t2;
        refill();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, instr_req}, 32'h0);
        chk("rst_addr", instr_addr, BOOT);
        chk("rst_value", {31'b0, instr_value}, 32'h0);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_payload", instr_payload, 32'h0);
        chk("rst_pred", {31'b0, branch_prediction_id}, 32'h0);
        chk("rst_ferr", {31'b0, instr_fetch_error}, 32'h0);

        // Straight-line fetch, gnt always, one-cycle response latency.
        phase = 1;
        @(posedge clk); #2;
        reset_n = 1'b1; ready_id = 1'b1;
        req_cyc = -1;
        for (int i = 0; i < 6 && req_cyc < 0; i++) begin
            @(negedge clk);
            if (instr_req) req_cyc = cyc;
        end
        chk("first_req_seen", {31'b0, req_cyc >= 0}, 32'h1);
        chk("first_addr", instr_addr, BOOT);
        val_cyc = -1;
        for (int i = 0; i < 10 && val_cyc < 0; i++) begin
            @(negedge clk);
            if (instr_value) val_cyc = cyc;
        end
        chk("value_latency", 32'(val_cyc - req_cyc), 32'd2);
        repeat (25) @(posedge clk);
        chk("bp_seen", {31'b0, bp_done}, 32'h1);

        // Stall decode: buffer fills to FIFO_DEPTH, requests stop, then drain without gaps.
        phase = 2;
        @(posedge clk); #2;
        do_redirect(1'b0, 1'b1, 32'h0, 32'h400);
        repeat (2) @(posedge clk);
        #2 ready_id = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_req", {31'b0, instr_req}, 32'h0);
        chk("stall_value", {31'b0, instr_value}, 32'h1);
        @(posedge clk); #2 ready_id = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_value_%0d", i), {31'b0, instr_value}, 32'h1);
        end

        // EX redirect with responses still in flight.
        lat_min = 3; lat_max = 3;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (pend_q.size() < 2 && n < 30);
        chk("two_outstanding", {31'b0, pend_q.size() >= 2}, 32'h1);
        do_redirect(1'b0, 1'b1, 32'h0, 32'h200);
        wait_pop("redirect_pc", 32'h200);

        // Controller redirect wins over EX in the same cycle.
        lat_min = 1; lat_max = 1;
        repeat (5) @(posedge clk); #2;
        do_redirect(1'b1, 1'b1, 32'h1000, 32'h300);
        wait_pop("pcset_priority", 32'h1000);

        // Randomised traffic, backpressure and redirects.
        phase = 3;
        gnt_pct = 60; rv_pct = 70; lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            ready_id = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 3) begin
                r  = $urandom_range(2);
                t1 = ($urandom_range(3) == 0) ? 32'($urandom_range(32'h100, 32'h80)) : 32'($urandom_range(32'h7FFF));
                t2 = 32'($urandom_range(32'h7FFF));
                do_redirect(r != 1, r != 0, t1, t2);
            end
        end
        chk("progress", {31'b0, (pops - p0) > 200}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
